// File: rtl/t05_bitstream_arbiter.sv
// Two-source bit-serial packer: grants one producer per session, packs bits MSB-first
// into WORD_W-bit words and writes them to SRAM over a req/ack port, with zero-padded flush.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | no owner; arbitrates src0 > src1 > flush
//   SRC0    | src0 owns the packer, bits accepted
//   SRC1    | src1 owns the packer, bits accepted
//   WAIT_WR | full word on wr_data, waiting for wr_ack
//   FLUSH   | write out the partial word (if any), padded with zeros
//   FIN     | flush_done pulse, then back to IDLE
module t05_bitstream_arbiter #(
    parameter int WORD_W    = 32,
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              src0_req,
    input  logic              src0_bit,
    input  logic              src0_valid,
    input  logic              src0_done,
    output logic              src0_gnt,
    output logic              src0_ready,
    input  logic              src1_req,
    input  logic              src1_bit,
    input  logic              src1_valid,
    input  logic              src1_done,
    output logic              src1_gnt,
    output logic              src1_ready,
    input  logic              flush,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    input  logic              wr_ack,
    output logic [31:0]       total_bits,
    output logic              flush_done,
    output logic              busy
);

    localparam int CNT_W = $clog2(WORD_W) + 1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SRC0    = 3'd1;
    localparam logic [2:0] ST_SRC1    = 3'd2;
    localparam logic [2:0] ST_WAIT_WR = 3'd3;
    localparam logic [2:0] ST_FLUSH   = 3'd4;
    localparam logic [2:0] ST_FIN     = 3'd5;

    logic [2:0]        state;
    logic [2:0]        ret_state;
    logic [WORD_W-1:0] sr;
    logic [WORD_W-1:0] sr_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  shamt;
    logic              accept;
    logic              acc_bit;
    logic              sess_done;
    logic              word_full;

    assign src0_ready = src0_gnt && (state == ST_SRC0);
    assign src1_ready = src1_gnt && (state == ST_SRC1);
    assign busy       = (state != ST_IDLE);

    always_comb begin
        accept    = (src0_valid && src0_ready) || (src1_valid && src1_ready);
        acc_bit   = src1_ready ? src1_bit : src0_bit;
        sess_done = (src0_done && src0_ready) || (src1_done && src1_ready);
        sr_next   = {sr[WORD_W-2:0], acc_bit};
        word_full = accept && (cnt == CNT_W'(WORD_W - 1));
        // Left-align the partial word so the first accepted bit lands on the MSB.
        shamt     = CNT_W'(WORD_W) - cnt;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= ST_IDLE;
            ret_state  <= ST_IDLE;
            src0_gnt   <= 1'b0;
            src1_gnt   <= 1'b0;
            sr         <= '0;
            cnt        <= '0;
            wr_req     <= 1'b0;
            wr_addr    <= ADDR_W'(BASE_ADDR);
            wr_data    <= '0;
            total_bits <= '0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (src0_req) begin
                        src0_gnt <= 1'b1;
                        state    <= ST_SRC0;
                    end else if (src1_req) begin
                        src1_gnt <= 1'b1;
                        state    <= ST_SRC1;
                    end else if (flush) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_SRC0, ST_SRC1: begin
                    if (accept) begin
                        sr         <= sr_next;
                        cnt        <= cnt + CNT_W'(1);
                        total_bits <= total_bits + 32'd1;
                    end
                    if (word_full) begin
                        wr_data   <= sr_next;
                        wr_req    <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_WAIT_WR;
                        ret_state <= sess_done ? ST_IDLE : state;
                    end else if (sess_done) begin
                        state <= ST_IDLE;
                    end
                    if (sess_done) begin
                        src0_gnt <= 1'b0;
                        src1_gnt <= 1'b0;
                    end
                end
                ST_WAIT_WR: begin
                    if (wr_req && wr_ack) begin
                        wr_req  <= 1'b0;
                        wr_addr <= wr_addr + ADDR_W'(1);
                        state   <= ret_state;
                    end
                end
                ST_FLUSH: begin
                    if (cnt == '0) begin
                        state      <= ST_FIN;
                        flush_done <= 1'b1;
                    end else if (!wr_req) begin
                        wr_data <= sr << shamt;
                        wr_req  <= 1'b1;
                    end else if (wr_ack) begin
                        wr_req     <= 1'b0;
                        wr_addr    <= wr_addr + ADDR_W'(1);
                        cnt        <= '0;
                        state      <= ST_FIN;
                        flush_done <= 1'b1;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t05_bitstream_arbiter.sv
// Bench for t05_bitstream_arbiter: table of session scenarios, hand-written corner
// sequences, and random multi-session traffic checked against a bit-queue model.
module tb_t05_bitstream_arbiter;

    logic        clk;
    logic        nrst;
    logic        src0_req, src0_bit, src0_valid, src0_done, src0_gnt, src0_ready;
    logic        src1_req, src1_bit, src1_valid, src1_done, src1_gnt, src1_ready;
    logic        flush;
    logic        wr_req;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic [31:0] total_bits;
    logic        flush_done;
    logic        busy;

    t05_bitstream_arbiter dut (
        .clk(clk), .nrst(nrst),
        .src0_req(src0_req), .src0_bit(src0_bit), .src0_valid(src0_valid),
        .src0_done(src0_done), .src0_gnt(src0_gnt), .src0_ready(src0_ready),
        .src1_req(src1_req), .src1_bit(src1_bit), .src1_valid(src1_valid),
        .src1_done(src1_done), .src1_gnt(src1_gnt), .src1_ready(src1_ready),
        .flush(flush), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .total_bits(total_bits), .flush_done(flush_done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          ready_viol = 0;
    int          ack_delay = 0;
    bit          rand_ack  = 0;
    logic [15:0] wq_addr[$];
    logic [31:0] wq_data[$];
    bit          model[$];

    typedef struct {
        bit          src;
        int          n;
        logic [63:0] pat;
        bit          done_last;
        int          delay;
        int          exp_n;
        logic [31:0] d0;
        logic [31:0] d1;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write capture: a write completes on any edge where req and ack are both high.
    always @(posedge clk) begin
        if (nrst && wr_req && wr_ack) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
        end
    end

    // SRAM-side responder with programmable or random ack latency.
    initial begin
        int cnt;
        int cur;
        bit in_wait;
        wr_ack  = 1'b0;
        in_wait = 0;
        cnt     = 0;
        cur     = 0;
        forever begin
            @(posedge clk);
            #1;
            if (wr_req && !wr_ack) begin
                if (!in_wait) begin
                    in_wait = 1;
                    cnt     = 0;
                    cur     = rand_ack ? int'($urandom_range(0, 4)) : ack_delay;
                end
                if (cnt >= cur) wr_ack = 1'b1;
                else cnt++;
            end else begin
                wr_ack  = 1'b0;
                in_wait = 0;
            end
        end
    end

    function automatic logic rdy(input bit s);
        return s ? src1_ready : src0_ready;
    endfunction

    function automatic logic gnt(input bit s);
        return s ? src1_gnt : src0_gnt;
    endfunction

    task automatic drive(input bit s, input logic req, input logic v, input logic b, input logic d);
        src0_req = 1'b0; src0_valid = 1'b0; src0_bit = 1'b0; src0_done = 1'b0;
        src1_req = 1'b0; src1_valid = 1'b0; src1_bit = 1'b0; src1_done = 1'b0;
        if (s) begin
            src1_req = req; src1_valid = v; src1_bit = b; src1_done = d;
        end else begin
            src0_req = req; src0_valid = v; src0_bit = b; src0_done = d;
        end
    endtask

    task automatic do_reset();
        nrst  = 1'b0;
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        nrst = 1'b1;
        tick();
        wq_addr.delete();
        wq_data.delete();
        model.delete();
    endtask

    task automatic send_session(input bit s, input int n, input logic [63:0] pat,
                                input bit done_last, input bit gaps, input bit wait_idle);
        bit got;
        drive(s, 1'b1, 1'b0, 1'b0, 1'b0);
        got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            tick();
            if (gnt(s)) got = 1;
        end
        chk("gnt_wait", 64'(got), 64'd1);
        drive(s, 1'b0, 1'b0, 1'b0, 1'b0);
        if (!got) return;
        for (int i = n - 1; i >= 0; i--) begin
            drive(s, 1'b0, 1'b1, pat[i], done_last && (i == 0));
            got = 0;
            for (int k = 0; k < 200 && !got; k++) begin
                if (wr_req && rdy(s)) ready_viol++;
                if (rdy(s)) begin
                    model.push_back(pat[i]);
                    got = 1;
                end
                tick();
            end
            drive(s, 1'b0, 1'b0, 1'b0, 1'b0);
            if (!got) begin
                chk("accept_wait", 64'd0, 64'd1);
                return;
            end
            if (gaps && $urandom_range(0, 3) == 0) tick();
        end
        if (!done_last) begin
            got = 0;
            for (int k = 0; k < 200 && !got; k++) begin
                if (rdy(s)) got = 1;
                else tick();
            end
            chk("done_wait", 64'(got), 64'd1);
            drive(s, 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
            drive(s, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        if (wait_idle) begin
            got = 0;
            for (int k = 0; k < 200 && !got; k++) begin
                if (!busy) got = 1;
                else tick();
            end
            chk("idle_wait", 64'(got), 64'd1);
            chk("gnt_released", 64'(gnt(s)), 64'd0);
        end
    endtask

    task automatic do_flush();
        bit got;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        got = 0;
        for (int k = 0; k < 100 && !got; k++) begin
            if (flush_done) got = 1;
            else tick();
        end
        chk("flush_done_wait", 64'(got), 64'd1);
        tick();
    endtask

    initial begin
        logic [31:0] w;
        int          nw;
        int          idx;

        vecs[0] = '{1'b0,  9, 64'h141,               1'b0, 0, 1, 32'hA080_0000, 32'h0};
        vecs[1] = '{1'b1, 32, 64'hDEAD_BEEF,         1'b1, 5, 1, 32'hDEAD_BEEF, 32'h0};
        vecs[2] = '{1'b0, 32, 64'h1234_5678,         1'b0, 1, 1, 32'h1234_5678, 32'h0};
        vecs[3] = '{1'b1,  4, 64'hB,                 1'b0, 2, 1, 32'hB000_0000, 32'h0};
        vecs[4] = '{1'b0, 40, 64'hCA_FEF0_0DAB,      1'b1, 3, 2, 32'hCAFE_F00D, 32'hAB00_0000};
        vecs[5] = '{1'b0, 32, 64'h0F0F_1234,         1'b1, 0, 1, 32'h0F0F_1234, 32'h0};
        vecs[6] = '{1'b1, 64, 64'h0123_4567_89AB_CDEF, 1'b0, 0, 2, 32'h0123_4567, 32'h89AB_CDEF};

        // Reset values, observed while reset is still asserted.
        nrst  = 1'b0;
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #12;
        chk("rst_gnt0", 64'(src0_gnt), 64'd0);
        chk("rst_gnt1", 64'(src1_gnt), 64'd0);
        chk("rst_ready", 64'({src0_ready, src1_ready}), 64'd0);
        chk("rst_wr_req", 64'(wr_req), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_total", 64'(total_bits), 64'd0);
        chk("rst_flags", 64'({flush_done, busy}), 64'd0);

        // Table-driven single-session scenarios, each followed by a flush.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            ready_viol = 0;
            ack_delay  = vecs[v].delay;
            send_session(vecs[v].src, vecs[v].n, vecs[v].pat, vecs[v].done_last, 1'b0, 1'b1);
            do_flush();
            chk($sformatf("v%0d_nwrites", v), 64'(wq_data.size()), 64'(vecs[v].exp_n));
            if (wq_data.size() > 0) begin
                chk($sformatf("v%0d_data0", v), 64'(wq_data[0]), 64'(vecs[v].d0));
                chk($sformatf("v%0d_addr0", v), 64'(wq_addr[0]), 64'd0);
            end
            if (wq_data.size() > 1) begin
                chk($sformatf("v%0d_data1", v), 64'(wq_data[1]), 64'(vecs[v].d1));
                chk($sformatf("v%0d_addr1", v), 64'(wq_addr[1]), 64'd1);
            end
            chk($sformatf("v%0d_total", v), 64'(total_bits), 64'(vecs[v].n));
            chk($sformatf("v%0d_addr_end", v), 64'(wr_addr), 64'(vecs[v].exp_n));
            chk($sformatf("v%0d_ready_in_wait", v), 64'(ready_viol), 64'd0);
        end
        ack_delay = 0;

        // Simultaneous requests: src0 first, src1 only after an idle cycle.
        do_reset();
        src0_req = 1'b1;
        src1_req = 1'b1;
        tick();
        chk("prio_gnt0", 64'(src0_gnt), 64'd1);
        chk("prio_gnt1", 64'(src1_gnt), 64'd0);
        src0_req  = 1'b0;
        src0_done = 1'b1;
        tick();
        src0_done = 1'b0;
        chk("prio_release_gnt0", 64'(src0_gnt), 64'd0);
        chk("prio_idle_gnt1", 64'(src1_gnt), 64'd0);
        chk("prio_idle_busy", 64'(busy), 64'd0);
        tick();
        chk("prio_gnt1_late", 64'(src1_gnt), 64'd1);
        src1_req  = 1'b0;
        src1_done = 1'b1;
        tick();
        src1_done = 1'b0;
        chk("prio_release_gnt1", 64'(src1_gnt), 64'd0);

        // Flush with nothing pending: no write, pulse two cycles after flush.
        do_reset();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush0_c1_done", 64'(flush_done), 64'd0);
        chk("flush0_c1_busy", 64'(busy), 64'd1);
        chk("flush0_c1_req", 64'(wr_req), 64'd0);
        tick();
        chk("flush0_c2_done", 64'(flush_done), 64'd1);
        chk("flush0_c2_req", 64'(wr_req), 64'd0);
        tick();
        chk("flush0_c3_done", 64'(flush_done), 64'd0);
        chk("flush0_c3_busy", 64'(busy), 64'd0);
        chk("flush0_nwrites", 64'(wq_data.size()), 64'd0);

        // Reset while a write is pending.
        do_reset();
        ack_delay = 1000;
        send_session(1'b0, 32, 64'h5555_AAAA, 1'b1, 1'b0, 1'b0);
        tick();
        chk("rstw_req_high", 64'(wr_req), 64'd1);
        chk("rstw_data", 64'(wr_data), 64'h5555_AAAA);
        #2;
        nrst = 1'b0;
        #1;
        chk("rstw_req_low", 64'(wr_req), 64'd0);
        chk("rstw_addr", 64'(wr_addr), 64'd0);
        chk("rstw_total", 64'(total_bits), 64'd0);
        chk("rstw_busy", 64'(busy), 64'd0);
        #3;
        nrst      = 1'b1;
        ack_delay = 0;
        tick();

        // Random multi-session traffic; partial words carry across sessions.
        do_reset();
        rand_ack   = 1;
        ready_viol = 0;
        for (int s = 0; s < 12; s++) begin
            send_session(1'($urandom_range(0, 1)), int'($urandom_range(1, 64)),
                         {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
        end
        do_flush();
        nw = (model.size() + 31) / 32;
        chk("rnd_nwrites", 64'(wq_data.size()), 64'(nw));
        for (int i = 0; i < nw && i < wq_data.size(); i++) begin
            w = '0;
            for (int b = 0; b < 32; b++) begin
                idx = i * 32 + b;
                w = {w[30:0], (idx < model.size()) ? model[idx] : 1'b0};
            end
            chk($sformatf("rnd_word%0d", i), 64'(wq_data[i]), 64'(w));
            chk($sformatf("rnd_addr%0d", i), 64'(wq_addr[i]), 64'(i));
        end
        chk("rnd_total", 64'(total_bits), 64'(model.size()));
        chk("rnd_ready_in_wait", 64'(ready_viol), 64'd0);
        rand_ack = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/t05_bitstream_arbiter.md
Name: t05_bitstream_arbiter

Overview:
- Shares one SRAM write port between two bit-serial producers of the compression output: src0 (header synthesis stream) and src1 (codeword stream).
- Grants one producer at a time for a whole session and packs its accepted bits MSB-first into WORD_W-bit words.
- Issues each full word as an SRAM write with a req/ack handshake; on request, flushes a final partial word padded with zeros.
- Sits between the header/codeword generators and the SRAM bus wrapper.

Parameters:
- WORD_W, 32, packed word width; must be a power of two, at least 8.
- ADDR_W, 16, word address width.
- BASE_ADDR, 0, word address of the first write after reset.

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- src0_req  in  1  src0 requests a session; level, held until granted.
- src0_bit  in  1  data bit from src0.
- src0_valid  in  1  src0_bit is valid this cycle.
- src0_done  in  1  last cycle of the src0 session; may coincide with src0_valid.
- src0_gnt  out  1  src0 owns the packer.
- src0_ready  out  1  src0 bit is accepted this cycle when src0_valid is high.
- src1_req, src1_bit, src1_valid, src1_done, src1_gnt, src1_ready: same as src0, for src1.
- flush  in  1  end-of-stream pulse; accepted only in IDLE.
- wr_req  out  1  write request, held until acked.
- wr_addr  out  ADDR_W  word address.
- wr_data  out  WORD_W  packed word.
- wr_ack  in  1  write accepted.
- total_bits  out  32  count of accepted bits since reset, wraps at 2^32.
- flush_done  out  1  one-cycle pulse when the flush completes.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (nrst low, asynchronous): state IDLE; all gnt, ready, wr_req, flush_done and busy outputs 0; wr_data 0; wr_addr BASE_ADDR; total_bits 0; bit count 0.
- States: IDLE, SRC0, SRC1, WAIT_WR, FLUSH, FIN.
- IDLE:
  - src0_req wins, then src1_req, then flush.
  - A request moves to SRC0 or SRC1 next cycle. That srcN_gnt is registered and stays high for the whole session.
  - flush moves to FLUSH.
- srcN_ready = srcN_gnt AND state is SRCn (combinational). It is low in WAIT_WR.
- A bit is accepted when srcN_valid and srcN_ready are both high:
  - shift register becomes {sr[WORD_W-2:0], bit};
  - bit count and total_bits increment.
- When the accepted bit is the WORD_W-th bit:
  - next cycle: wr_data gets the shift register, wr_req goes to 1, bit count goes to 0;
  - state goes to WAIT_WR; the return state (SRCn, or IDLE if srcN_done was also high that cycle) is saved.
- WAIT_WR:
  - wr_ack is sampled while wr_req is high.
  - On ack: wr_req drops next cycle, wr_addr increments by 1 (wraps at 2^ADDR_W), and the FSM returns to the saved state.
  - wr_ack is ignored when wr_req is low.
- srcN_done in SRCn: releases the session; gnt drops next cycle and the state goes to IDLE. A bit on the same cycle is still accepted.
- Sessions switch only through IDLE, so there is a minimum of one idle cycle between sessions. The fixed priority is intentional: the header must precede the codes.
- A partial word carries across sessions; the bits of both sources are concatenated without padding.
- FLUSH:
  - Bit count 0: no write; go to FIN.
  - Otherwise: wr_data = shift register << (WORD_W - count), so the first bit sits at the MSB and the LSBs are 0. Assert wr_req, wait for ack, clear the count, then go to FIN.
- FIN: flush_done is high for one cycle, then IDLE.
- flush and srcN_req in FLUSH or FIN are ignored.
- Reset mid-write: wr_req drops immediately and the partial word is lost.

Test Plan:
- src0 sends 9 bits 1_0100_0001 then done, then flush → one write at addr 0: wr_data=0xA080_0000; flush_done pulses; total_bits=9.
- 32 bits 0xDEADBEEF from src1 with wr_ack delayed 5 cycles → src1_ready low for those cycles; one write of 0xDEADBEEF at addr 0; wr_addr=1 afterwards.
- src0_req and src1_req rise in the same cycle → src0_gnt first; src1_gnt only after src0_done plus one IDLE cycle.
- 32nd bit coincides with src0_done → write issued; then IDLE; src0_gnt=0.
- flush with 0 pending bits → no wr_req; flush_done 2 cycles after flush.
- nrst asserted while wr_req is high → wr_req=0 asynchronously; wr_addr=BASE_ADDR; total_bits=0.
